candy_mem_arb: RTL and testbench
================================

CANDY_MEM_ARB -- requirements
Module: candy_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (matches register width).
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles waited in RD_WAIT for read data.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port if_req  in  1  fetch read request, held until if_ack.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch address, stable while if_req.
REQ-008 SHALL have port if_ack  out  1  one-cycle pulse, fetch complete.
REQ-009 SHALL have port if_rdata  out  DATA_W  fetched word, valid only while if_ack=1.
REQ-010 SHALL have port wb_req  in  1  writeback store request, held until wb_ack.
REQ-011 SHALL have port wb_addr  in  ADDR_W  store address.
REQ-012 SHALL have port wb_wdata  in  DATA_W  store data.
REQ-013 SHALL have port wb_ack  out  1  one-cycle pulse, store complete.
REQ-014 SHALL have port sram_re  out  1  SRAM read strobe.
REQ-015 SHALL have port sram_we  out  1  SRAM write strobe.
REQ-016 SHALL have port sram_addr  out  ADDR_W  SRAM address.
REQ-017 SHALL have port sram_wdata  out  DATA_W  SRAM write data.
REQ-018 SHALL have port sram_rdata  in  DATA_W  SRAM read data.
REQ-019 SHALL have port sram_rdata_ready  in  1  SRAM read data valid.
REQ-020 SHALL have port busy  out  1  high in every state except IDLE.
REQ-021 SHALL have port err  out  1  sticky read-timeout flag.

Function
REQ-022 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
REQ-023 SHALL, in IDLE with wb_req=1, go to WR; wb_req wins over if_req when both are high.
REQ-024 SHALL, in IDLE with only if_req=1, go to RD_ISSUE; neither high: stay IDLE.
REQ-025 SHALL register addr/wdata of the accepted request on the IDLE->RD_ISSUE/WR edge; later input changes are ignored until ack.
REQ-026 SHALL, in WR, drive sram_we=1 for exactly one cycle with the latched addr/data, then go to DONE.
REQ-027 SHALL, in RD_ISSUE, drive sram_re=1 for exactly one cycle, then go to RD_WAIT; sram_rdata_ready is ignored in RD_ISSUE.
REQ-028 SHALL, in RD_WAIT, capture sram_rdata into if_rdata when sram_rdata_ready=1 and go to DONE.
REQ-029 SHALL count RD_WAIT cycles; if TIMEOUT cycles pass without ready, go to DONE with if_rdata=0 and set err=1.
REQ-030 SHALL, in DONE, pulse exactly one of if_ack/wb_ack (matching the served request) for one cycle, then go to IDLE.
REQ-031 SHALL give write latency: wb_req sampled at edge N -> sram_we in cycle N+1 -> wb_ack in cycle N+2.
REQ-032 SHALL give read latency: if_req sampled at edge N -> sram_re in cycle N+1 -> if_ack one cycle after the ready-sampling edge.
REQ-033 SHALL serve at most one write between consecutive fetches while if_req is pending (no fetch starvation).
REQ-034 SHALL drive sram_re, sram_we, if_ack and wb_ack to 0 in all states where they are not explicitly asserted.
REQ-035 SHALL ignore a sram_rdata_ready that arrives outside RD_WAIT.

Reset
REQ-036 SHALL, on rst=1, go to IDLE and clear all outputs, latched addr/data and the timeout counter to 0, including err.
REQ-037 SHALL, when reset occurs mid-transaction, abort it and never issue the ack for that transaction.

Structure
REQ-038 SHALL take state encodings and the default widths from the shared candy defines header.
REQ-039 SHALL be a single module with no sub-modules; the fairness bit and timeout counter are local registers.

Verification
REQ-040 SHALL cover: if_req, addr 0x0010, SRAM ready 2 cycles after sram_re with 0x12345678 -> if_ack one cycle later, if_rdata=0x12345678.
REQ-041 SHALL cover: wb_req, addr 0x0020, data 0xCAFEBABE -> sram_we in cycle N+1 with those values, wb_ack in cycle N+2.
REQ-042 SHALL cover: if_req and wb_req both high, held -> write served first, then fetch; no further write until the fetch is acked.
REQ-043 SHALL cover: read with no ready -> if_ack after 15 wait cycles, if_rdata=0, err=1 and held until rst.
REQ-044 SHALL cover: rst asserted in RD_WAIT -> next cycle IDLE, busy=0, no if_ack even if ready then arrives.
REQ-045 SHALL cover: if_addr changed mid-read -> SRAM still sees the originally latched address.

Source files
------------

// File: rtl/candy_mem_arb_pkg.sv
// Shared definitions for the candy SRAM arbiter.
//   - default address/data widths and read timeout
//   - FSM state encoding
//   - request selection helper (writeback priority with fetch fairness)
package candy_mem_arb_pkg;

  localparam int CANDY_ADDR_W  = 16;
  localparam int CANDY_DATA_W  = 32;
  localparam int CANDY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } arb_state_e;

  // Writeback normally wins, except right after a write while a fetch is
  // still waiting: then the fetch goes first so it can never be starved.
  function automatic logic choose_write(input logic wb_req,
                                        input logic if_req,
                                        input logic last_was_wr);
    return wb_req && !(if_req && last_was_wr);
  endfunction

endpackage

// File: rtl/candy_mem_arb.sv
// Single-port SRAM arbiter between an instruction-fetch read port and a
// writeback store port. One transaction is in flight at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack) and its address
//   if_ack/if_rdata     one-cycle completion pulse and fetched word
//   wb_req/wb_addr/     store request (held until wb_ack), address, data
//   wb_wdata
//   wb_ack              one-cycle store completion pulse
//   sram_re/sram_we     SRAM read / write strobes (one cycle each)
//   sram_addr/wdata     latched address and store data towards the SRAM
//   sram_rdata/ready    SRAM read data and its valid flag
//   busy                high whenever not IDLE
//   err                 sticky read-timeout flag, cleared only by rst
module candy_mem_arb
  import candy_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = CANDY_ADDR_W,
  parameter int DATA_W  = CANDY_DATA_W,
  parameter int TIMEOUT = CANDY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_ack,
  output logic              sram_re,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rdata_ready,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              srv_rd_q;     // transaction in flight is a fetch
  logic              last_wr_q;    // most recently accepted request was a write
  logic              err_q;

  logic              accept_wr;
  logic              accept_rd;
  logic              rd_hit;
  logic              rd_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; every strobe is a pure function of the
  // registered state, so they are one-cycle pulses by construction.
  always_comb begin
    state_d    = state_q;
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    if_ack     = 1'b0;
    wb_ack     = 1'b0;
    busy       = 1'b1;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    rd_hit     = 1'b0;
    rd_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (choose_write(wb_req, if_req, last_wr_q)) begin
          accept_wr = 1'b1;
          state_d   = WR;
        end else if (if_req) begin
          accept_rd = 1'b1;
          state_d   = RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        // A ready seen here belongs to nothing we issued; ignore it.
        sram_re = 1'b1;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (sram_rdata_ready) begin
          rd_hit  = 1'b1;
          state_d = DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          rd_timeout = 1'b1;
          state_d    = DONE;
        end
      end

      WR: begin
        sram_we = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        if_ack  = srv_rd_q;
        wb_ack  = !srv_rd_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, read capture, wait counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      srv_rd_q   <= 1'b0;
      last_wr_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept_wr) begin
        addr_q    <= wb_addr;
        wdata_q   <= wb_wdata;
        srv_rd_q  <= 1'b0;
        last_wr_q <= 1'b1;
      end else if (accept_rd) begin
        addr_q    <= if_addr;
        srv_rd_q  <= 1'b1;
        last_wr_q <= 1'b0;
      end

      if (rd_hit) begin
        rdata_q <= sram_rdata;
      end else if (rd_timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end

      // Counts completed RD_WAIT cycles; zero everywhere else so each read
      // starts with a fresh budget.
      if (state_q == RD_WAIT && !rd_hit && !rd_timeout) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_candy_mem_arb.sv
// Bench for candy_mem_arb: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level
// model that tracks the age of the current transaction.
module tb_candy_mem_arb;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        wb_req;
  logic [15:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_ack;
  logic        sram_re;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_rdata_ready;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  candy_mem_arb dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_ack          (if_ack),
    .if_rdata        (if_rdata),
    .wb_req          (wb_req),
    .wb_addr         (wb_addr),
    .wb_wdata        (wb_wdata),
    .wb_ack          (wb_ack),
    .sram_re         (sram_re),
    .sram_we         (sram_we),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .sram_rdata_ready(sram_rdata_ready),
    .busy            (busy),
    .err             (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_on = 0;
  bit          m_active;
  bit          m_wr;
  int          m_age;       // 1 = cycle right after the request was accepted
  bit          m_rd_done;
  bit          m_prev_wr;
  bit          m_err;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  always @(negedge clk) begin
    bit e_re, e_we, e_if_ack, e_wb_ack;
    e_re     = m_active && !m_wr && m_age == 1;
    e_we     = m_active &&  m_wr && m_age == 1;
    e_wb_ack = m_active &&  m_wr && m_age == 2;
    e_if_ack = m_active && !m_wr && m_rd_done;
    if (m_on) begin
      chk("busy", busy, m_active);
      chk("sram_re", sram_re, e_re);
      chk("sram_we", sram_we, e_we);
      chk("wb_ack", wb_ack, e_wb_ack);
      chk("if_ack", if_ack, e_if_ack);
      chk("err", err, m_err);
      if (e_re || e_we) chk("sram_addr", sram_addr, m_addr);
      if (e_we) chk("sram_wdata", sram_wdata, m_wdata);
      if (e_if_ack) chk("if_rdata", if_rdata, m_rdata);
    end
    // advance the model with the inputs the DUT samples at the next edge
    if (rst) begin
      m_on      = 1;
      m_active  = 0;
      m_err     = 0;
      m_prev_wr = 0;
      m_rd_done = 0;
    end else if (m_on) begin
      if (!m_active) begin
        if (wb_req && !(if_req && m_prev_wr)) begin
          m_active = 1; m_wr = 1; m_age = 1;
          m_addr = wb_addr; m_wdata = wb_wdata; m_prev_wr = 1;
        end else if (if_req) begin
          m_active = 1; m_wr = 0; m_age = 1; m_rd_done = 0;
          m_addr = if_addr; m_prev_wr = 0;
        end
      end else if (e_wb_ack || e_if_ack) begin
        m_active = 0;
      end else begin
        if (!m_wr && m_age >= 2 && !m_rd_done) begin
          if (sram_rdata_ready) begin
            m_rd_done = 1;
            m_rdata   = sram_rdata;
          end else if (m_age == TO + 1) begin
            m_rd_done = 1;
            m_rdata   = '0;
            m_err     = 1;
          end
        end
        m_age++;
      end
    end
  end

  // ---------------- requester handshake helpers ----------------
  bit if_ack_seen = 0;
  bit wb_ack_seen = 0;

  always @(negedge clk) begin
    if_ack_seen = if_ack;
    wb_ack_seen = wb_ack;
  end

  // Advance one cycle; requests are released the cycle after their ack.
  task automatic tick();
    @(posedge clk);
    #1;
    if (if_ack_seen) if_req = 1'b0;
    if (wb_ack_seen) wb_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    wb_req = 0; wb_addr = '0; wb_wdata = '0;
    sram_rdata = '0; sram_rdata_ready = 0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_rdata", if_rdata, 32'h0);
    chk("rst_strobes", {sram_re, sram_we, if_ack, wb_ack}, 4'b0000);
    rst = 1'b0;
    tick();

    // single write
    wb_req = 1; wb_addr = 16'h0020; wb_wdata = 32'hCAFEBABE;
    tick();
    chk("wr_we", sram_we, 1'b1);
    chk("wr_addr", sram_addr, 32'h0020);
    chk("wr_data", sram_wdata, 32'hCAFEBABE);
    tick();
    chk("wr_ack", wb_ack, 1'b1);
    tick();
    chk("wr_idle", busy, 1'b0);

    // single read, ready two cycles after the strobe, address changed mid-read
    if_req = 1; if_addr = 16'h0010;
    tick();
    chk("rd_re", sram_re, 1'b1);
    chk("rd_addr", sram_addr, 32'h0010);
    if_addr = 16'hFFFF;
    tick();
    chk("rd_addr_held", sram_addr, 32'h0010);
    tick();
    sram_rdata_ready = 1; sram_rdata = 32'h12345678;
    tick();
    sram_rdata_ready = 0; sram_rdata = '0;
    chk("rd_ack", if_ack, 1'b1);
    chk("rd_data", if_rdata, 32'h12345678);
    tick();

    // both requesting: write first, then fetch, then the next write
    wb_req = 1; wb_addr = 16'h0030; wb_wdata = 32'h00000055;
    if_req = 1; if_addr = 16'h0040;
    tick();
    chk("fair_we1", {sram_we, sram_re}, 2'b10);
    chk("fair_addr1", sram_addr, 32'h0030);
    tick();
    chk("fair_wback1", wb_ack, 1'b1);
    tick();
    wb_req = 1; wb_addr = 16'h0031; wb_wdata = 32'h00000066;
    chk("fair_idle", busy, 1'b0);
    tick();
    chk("fair_re", {sram_we, sram_re}, 2'b01);
    chk("fair_addr2", sram_addr, 32'h0040);
    sram_rdata_ready = 1; sram_rdata = 32'h00000BAD;
    tick();
    sram_rdata = 32'h0F0F0F0F;
    tick();
    sram_rdata_ready = 0;
    chk("fair_ifack", if_ack, 1'b1);
    chk("fair_rdata", if_rdata, 32'h0F0F0F0F);
    tick();
    tick();
    chk("fair_we2", sram_we, 1'b1);
    chk("fair_addr3", sram_addr, 32'h0031);
    tick();
    chk("fair_wback2", wb_ack, 1'b1);
    tick();

    // read that never gets data
    if_req = 1; if_addr = 16'h0077;
    tick();
    chk("to_re", sram_re, 1'b1);
    n = 0;
    while (!if_ack && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_rdata", if_rdata, 32'h0);
    chk("to_err", err, 1'b1);
    repeat (3) tick();
    chk("to_err_sticky", err, 1'b1);

    // reset in the middle of a read wait
    if_req = 1; if_addr = 16'h0050;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; if_req = 0;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_err", err, 1'b0);
    sram_rdata_ready = 1; sram_rdata = 32'hDEADBEEF;
    tick();
    sram_rdata_ready = 0;
    chk("rstw_noack", if_ack, 1'b0);
    chk("rstw_idle", busy, 1'b0);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end else if (if_req && $urandom_range(0, 4) == 0) begin
        if_addr = 16'($urandom);
      end
      if (!wb_req && $urandom_range(0, 2) == 0) begin
        wb_req = 1; wb_addr = 16'($urandom); wb_wdata = $urandom;
      end else if (wb_req && $urandom_range(0, 4) == 0) begin
        wb_addr = 16'($urandom); wb_wdata = $urandom;
      end
      sram_rdata_ready = ($urandom_range(0, 9) < 2);
      sram_rdata = $urandom;
    end
    rst = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
